// File: rtl/alu_operand_stage.sv
// Decode/operand-select stage feeding the alu: builds a/b/op/rev plus rd/rd_we/illegal from one RV32I instruction.
// Latency: 1 cycle from accepted input to out_valid; full throughput with out_ready held high.
// Backpressure: single-entry output register; in_ready = !out_valid || out_ready, held entry stays frozen while out_ready is low.
//
// Ports:
//   clk, reset (async, active-high), flush (sync kill of held entry)
//   in_valid/in_ready, instr, pc, rs1_data, rs2_data  : upstream handshake and operands
//   wb_valid, wb_rd, wb_data                          : writeback bypass source
//   out_valid/out_ready, a, b, op, rev, rd, rd_we, illegal : registered result toward the alu
//
// Build option: define ALU_OPSTAGE_BYPASS_EN to forward wb_data onto rs1/rs2 at load
// time when the writeback destination matches a source register (x0 never matches).
// Without it the wb_* ports are accepted but have no effect.

module alu_operand_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  op,
    output logic        rev,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;

    // Everything the alu needs for one instruction, kept as one word so the
    // output register is loaded and cleared as a unit.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        rev;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } opnd_t;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_u   = {instr[31:12], 12'b0};
    assign shamt   = {27'b0, instr[24:20]};

    // ------------------------------------------------------------------
    // Source operand selection (optional writeback forwarding)
    // ------------------------------------------------------------------
    logic [31:0] src1;
    logic [31:0] src2;

`ifdef ALU_OPSTAGE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // x0 is hardwired zero, so a writeback aimed at it must never forward.
    assign fwd1 = wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1_idx);
    assign fwd2 = wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2_idx);
    assign src1 = fwd1 ? wb_data : rs1_data;
    assign src2 = fwd2 ? wb_data : rs2_data;
`else
    logic unused_bypass;

    assign src1          = rs1_data;
    assign src2          = rs2_data;
    assign unused_bypass = ^{wb_valid, wb_rd, wb_data, rs1_idx};
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    opnd_t dec;
    logic  legal;

    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        dec.rd = instr[11:7];

        case (opcode)
            OPC_OP: begin
                dec.a   = src1;
                dec.b   = src2;
                dec.op  = funct3;
                dec.rev = instr[30];
                // Alternate encoding only exists for SUB and SRA.
                legal   = (funct7 == F7_BASE) ||
                          ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
            end

            OPC_OP_IMM: begin
                dec.a  = src1;
                dec.op = funct3;
                if (funct3 == F3_SLL) begin
                    dec.b = shamt;
                    legal = (funct7 == F7_BASE);
                end else if (funct3 == F3_SR) begin
                    dec.b   = shamt;
                    dec.rev = instr[30];
                    legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                end else begin
                    // instr[30] is immediate data here; ADDI must not turn into a subtract.
                    dec.b = imm_i;
                    legal = 1'b1;
                end
            end

            OPC_LUI: begin
                dec.b = imm_u;
                legal = 1'b1;
            end

            OPC_AUIPC: begin
                dec.a = pc;
                dec.b = imm_u;
                legal = 1'b1;
            end

            default: begin
                legal = 1'b0;
            end
        endcase

        // Illegal instructions present clean zero operands downstream.
        if (!legal) begin
            dec.a   = '0;
            dec.b   = '0;
            dec.op  = '0;
            dec.rev = 1'b0;
        end

        dec.illegal = !legal;
        dec.rd_we   = legal && (dec.rd != 5'd0);
    end

    // ------------------------------------------------------------------
    // Single-entry output register
    // ------------------------------------------------------------------
    opnd_t held_q;
    logic  valid_q;
    logic  load;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            held_q  <= '0;
        end else if (flush) begin
            // Kill wins over load and hold; the payload is left as-is.
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            held_q  <= dec;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign a         = held_q.a;
    assign b         = held_q.b;
    assign op        = held_q.op;
    assign rev       = held_q.rev;
    assign rd        = held_q.rd;
    assign rd_we     = held_q.rd_we;
    assign illegal   = held_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: hand-computed vectors for decode,
// backpressure, flush, async reset and writeback bypass.
module tb_alu_operand_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        rev;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] got[$];
    logic [31:0] exp_byp_a;
    logic [31:0] exp_byp_b;

    alu_operand_stage dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .rev       (rev),
        .rd        (rd),
        .rd_we     (rd_we),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake completed on the output side.
    always @(posedge clk) begin
        if (out_valid && out_ready)
            got.push_back(a);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge, then check the registered result.
    task automatic send(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2);
        instr    = i;
        pc       = p;
        rs1_data = r1;
        rs2_data = r2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                             input logic [2:0] eop, input logic erev, input logic [4:0] erd,
                             input logic ewe, input logic eill);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".a"},         a,                  ea);
        chk({tag, ".b"},         b,                  eb);
        chk({tag, ".op"},        {29'b0, op},        {29'b0, eop});
        chk({tag, ".rev"},       {31'b0, rev},       {31'b0, erev});
        chk({tag, ".rd"},        {27'b0, rd},        {27'b0, erd});
        chk({tag, ".rd_we"},     {31'b0, rd_we},     {31'b0, ewe});
        chk({tag, ".illegal"},   {31'b0, illegal},   {31'b0, eill});
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        pc        = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst.a",         a,                  32'd0);
        chk("rst.b",         b,                  32'd0);
        chk("rst.rd",        {27'b0, rd},        32'd0);
        chk("rst.illegal",   {31'b0, illegal},   32'd0);
        #10;
        reset = 1'b0;
        step();

        // Decode vectors
        send(32'h002081B3, 32'h0, 32'd5, 32'd3);
        check_all("add",   32'd5, 32'd3, 3'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        send(32'h402081B3, 32'h0, 32'd5, 32'd3);
        check_all("sub",   32'd5, 32'd3, 3'd0, 1'b1, 5'd3, 1'b1, 1'b0);
        send(32'hFFF00293, 32'h0, 32'd0, 32'd9);
        check_all("addi",  32'd0, 32'hFFFFFFFF, 3'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        send(32'h4043D313, 32'h0, 32'h80, 32'd9);
        check_all("srai",  32'h80, 32'd4, 3'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        send(32'h123450B7, 32'h40, 32'd7, 32'd9);
        check_all("lui",   32'd0, 32'h12345000, 3'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        send(32'h00001117, 32'h1000, 32'd7, 32'd9);
        check_all("auipc", 32'h1000, 32'h1000, 3'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        send(32'h00000073, 32'h0, 32'd7, 32'd9);
        check_all("ecall", 32'd0, 32'd0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        // SLL with the alternate funct7 is not a real encoding
        send(32'h402091B3, 32'h0, 32'd5, 32'd3);
        check_all("sllalt", 32'd0, 32'd0, 3'd0, 1'b0, 5'd3, 1'b0, 1'b1);
        // SLLI with bit 30 set is malformed
        send(32'h40409313, 32'h0, 32'd5, 32'd3);
        check_all("slli30", 32'd0, 32'd0, 3'd0, 1'b0, 5'd6, 1'b0, 1'b1);
        // ADDI x1,x0,0x400: bit 30 is immediate data, no subtract
        send(32'h40000093, 32'h0, 32'd0, 32'd3);
        check_all("addi30", 32'd0, 32'h400, 3'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        // ADD x0,x1,x2: legal but no writeback
        send(32'h00208033, 32'h0, 32'd5, 32'd3);
        check_all("addx0", 32'd5, 32'd3, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Drain, then stream three ADDs with a two-cycle stall
        step();
        chk("drain.out_valid", {31'b0, out_valid}, 32'd0);
        got.delete();
        instr    = 32'h002081B3;
        rs1_data = 32'd10;
        rs2_data = 32'd1;
        in_valid = 1'b1;
        step();                                   // A loaded
        chk("bp.a0", a, 32'd10);
        rs1_data  = 32'd11;                       // B presented
        out_ready = 1'b0;
        #1;
        chk("bp.in_ready_low", {31'b0, in_ready}, 32'd0);
        step();                                   // hold 1
        chk("bp.hold1.valid", {31'b0, out_valid}, 32'd1);
        chk("bp.hold1.a",     a,                  32'd10);
        chk("bp.hold1.rdy",   {31'b0, in_ready},  32'd0);
        step();                                   // hold 2
        chk("bp.hold2.a",     a,                  32'd10);
        chk("bp.hold2.b",     b,                  32'd1);
        out_ready = 1'b1;
        step();                                   // A consumed, B loaded
        chk("bp.a1", a, 32'd11);
        rs1_data = 32'd12;
        step();                                   // B consumed, C loaded
        chk("bp.a2", a, 32'd12);
        in_valid = 1'b0;
        step();                                   // C consumed
        chk("bp.empty",  {31'b0, out_valid}, 32'd0);
        chk("bp.count",  got.size(), 32'd3);
        if (got.size() == 3) begin
            chk("bp.order0", got[0], 32'd10);
            chk("bp.order1", got[1], 32'd11);
            chk("bp.order2", got[2], 32'd12);
        end

        // Flush while holding, with a concurrent input
        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'h77, 32'd1);
        chk("fl.held", {31'b0, out_valid}, 32'd1);
        flush    = 1'b1;
        instr    = 32'hFFF00293;
        in_valid = 1'b1;
        step();
        chk("fl.killed", {31'b0, out_valid}, 32'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl.dropped", {31'b0, out_valid}, 32'd0);

        // Flush while the stage is empty and ready: input still dropped
        flush    = 1'b1;
        in_valid = 1'b1;
        step();
        chk("fl2.dropped", {31'b0, out_valid}, 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;

        // Async reset between edges
        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'h99, 32'd1);
        chk("ar.held", {31'b0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.valid",    {31'b0, out_valid}, 32'd0);
        chk("ar.a",        a,                  32'd0);
        chk("ar.in_ready", {31'b0, in_ready},  32'd1);
        #2;
        reset     = 1'b0;
        out_ready = 1'b1;
        step();

        // Writeback bypass
`ifdef ALU_OPSTAGE_BYPASS_EN
        exp_byp_a = 32'h55;
        exp_byp_b = 32'h66;
`else
        exp_byp_a = 32'd1;
        exp_byp_b = 32'd2;
`endif
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        wb_data  = 32'h55;
        send(32'h002081B3, 32'h0, 32'd1, 32'd2);
        check_all("byp.rs1", exp_byp_a, 32'd2, 3'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        wb_rd   = 5'd2;
        wb_data = 32'h66;
        send(32'h002081B3, 32'h0, 32'd1, 32'd2);
        chk("byp.rs2.a", a, 32'd1);
        chk("byp.rs2.b", b, exp_byp_b);
        wb_rd   = 5'd0;
        wb_data = 32'h55;
        send(32'hFFF00293, 32'h0, 32'd0, 32'd2);
        chk("byp.x0.a", a, 32'd0);
        wb_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
